// File: rtl/spi_reg_burst_if.sv
// spi_reg_burst_if: SPI pins plus the register-file write strobe / read handshake.
interface spi_reg_burst_if #(
   parameter int ADDR_W = 6,
   parameter int REG_W  = 8
);
   logic              spi_clk;
   logic              spi_cs_n;
   logic              spi_mosi;
   logic              spi_miso;
   logic [ADDR_W-1:0] reg_addr;
   logic [REG_W-1:0]  reg_wdata;
   logic              reg_wr;
   logic              reg_rd;
   logic [REG_W-1:0]  reg_rdata;
   logic              reg_rdata_dv;
   logic              busy;
   logic              rd_underrun;
   modport slave (
      input  spi_clk, spi_cs_n, spi_mosi, reg_rdata, reg_rdata_dv,
      output spi_miso, reg_addr, reg_wdata, reg_wr, reg_rd, busy, rd_underrun
   );
   modport master (
      output spi_clk, spi_cs_n, spi_mosi, reg_rdata, reg_rdata_dv,
      input  spi_miso, reg_addr, reg_wdata, reg_wr, reg_rd, busy, rd_underrun
   );
endinterface

// File: rtl/spi_reg_burst.sv
// spi_reg_burst: SPI slave register port, all four SPI modes, burst read/write with optional
// address auto-increment; reads prefetch the next word as soon as the current one completes.
module spi_reg_burst #(
   parameter int ADDR_W     = 6,
   parameter int REG_W      = 8,
   parameter bit CPOL       = 1'b0,
   parameter bit CPHA       = 1'b0,
   parameter int RD_TIMEOUT = 4
) (
   input logic            clk,
   input logic            rstb,
   input logic            ena,
   spi_reg_burst_if.slave bus
);
   localparam int HDR_W = ADDR_W + 2;
   localparam int RX_W  = (HDR_W > REG_W) ? HDR_W : REG_W;
   localparam int CNT_W = $clog2(RX_W + 1);
   localparam int TO_W  = $clog2(RD_TIMEOUT + 2);

   typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_DATA, WR_DATA} state_t;

   state_t            state_q, state_d;
   logic [2:0]        sclk_q, cs_q;
   logic [1:0]        mosi_q;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [RX_W-2:0]   rx_q, rx_d;
   logic [REG_W-1:0]  shift_q, shift_d, wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              inc_q, inc_d, changed_q, changed_d;
   logic              wr_q, wr_d, rd_q, rd_d, unr_q, unr_d;
   logic              rise, fall, sample, change, cs_fall, cs_rise;
   logic              hdr_done, word_done, late;
   logic [HDR_W-1:0]  hdr;
   logic [REG_W-1:0]  word;

   // Cs_n sync resets low so a reset in the middle of a frame never fakes a cs_n fall.
   always_ff @(posedge clk or negedge rstb)
      if (!rstb) begin
         sclk_q <= {3{CPOL}};
         cs_q   <= '0;
         mosi_q <= '0;
      end else if (ena) begin
         sclk_q <= {sclk_q[1:0], bus.spi_clk};
         cs_q   <= {cs_q[1:0], bus.spi_cs_n};
         mosi_q <= {mosi_q[0], bus.spi_mosi};
      end

   assign rise      = ena & ~cs_q[1] & sclk_q[1] & ~sclk_q[2];
   assign fall      = ena & ~cs_q[1] & ~sclk_q[1] & sclk_q[2];
   assign sample    = (CPOL ^ CPHA) ? fall : rise;
   assign change    = (CPOL ^ CPHA) ? rise : fall;
   assign cs_fall   = ena & cs_q[2] & ~cs_q[1];
   assign cs_rise   = ena & ~cs_q[2] & cs_q[1];
   assign hdr       = {rx_q[HDR_W-2:0], mosi_q[1]};
   assign word      = {rx_q[REG_W-2:0], mosi_q[1]};
   assign hdr_done  = sample & (state_q == HDR) & (bit_cnt_q == CNT_W'(HDR_W - 1));
   assign word_done = sample & (bit_cnt_q == CNT_W'(REG_W - 1));
   assign late      = to_q > TO_W'(RD_TIMEOUT);

   always_ff @(posedge clk or negedge rstb)
      if (!rstb) state_q <= IDLE;
      else if (ena) state_q <= state_d;

   always_comb begin
      state_d = state_q;
      if (cs_rise) state_d = IDLE;
      else
         case (state_q)
            IDLE:    state_d = cs_fall ? HDR : IDLE;
            HDR:     state_d = hdr_done ? (hdr[HDR_W-1] ? WR_DATA : RD_REQ) : HDR;
            RD_REQ:  state_d = RD_DATA;
            RD_DATA: state_d = word_done ? RD_REQ : RD_DATA;
            default: state_d = state_q;
         endcase
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      shift_d   = shift_q;
      wdata_d   = wdata_q;
      addr_d    = wr_q ? addr_q + ADDR_W'(inc_q) : addr_q;
      to_d      = to_q;
      inc_d     = inc_q;
      changed_d = changed_q;
      wr_d      = 1'b0;
      rd_d      = state_q == RD_REQ;
      unr_d     = unr_q;
      if (state_q != IDLE && sample) begin
         rx_d      = {rx_q[RX_W-3:0], mosi_q[1]};
         bit_cnt_d = (bit_cnt_q == CNT_W'((state_q == HDR) ? HDR_W - 1 : REG_W - 1)) ? '0 : bit_cnt_q + 1'b1;
      end
      if (cs_fall) begin
         bit_cnt_d = '0;
         unr_d     = 1'b0;
      end
      if (hdr_done) begin
         addr_d = hdr[ADDR_W-1:0];
         inc_d  = hdr[HDR_W-2];
      end
      if (state_q == WR_DATA && word_done) begin
         wr_d    = 1'b1;
         wdata_d = word;
      end
      if (state_q == RD_REQ) begin
         shift_d   = '0;
         to_d      = '0;
         changed_d = 1'b0;
      end
      // A change edge with bit_cnt==0 is the word's first leading edge (CPHA=1) or the tail of the previous word (CPHA=0).
      if (state_q == RD_DATA) begin
         to_d = late ? to_q : to_q + 1'b1;
         if (change) begin
            changed_d = 1'b1;
            if (bit_cnt_q != '0) shift_d = {shift_q[REG_W-2:0], 1'b0};
         end
         if (bus.reg_rdata_dv) begin
            if (late || changed_q || bit_cnt_q != '0) unr_d = 1'b1;
            else shift_d = bus.reg_rdata;
         end
         if (word_done) addr_d = addr_q + ADDR_W'(inc_q);
      end
   end

   always_ff @(posedge clk or negedge rstb)
      if (!rstb) begin
         bit_cnt_q <= '0;
         rx_q      <= '0;
         shift_q   <= '0;
         wdata_q   <= '0;
         addr_q    <= '0;
         to_q      <= '0;
         inc_q     <= 1'b0;
         changed_q <= 1'b0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         unr_q     <= 1'b0;
      end else if (ena) begin
         bit_cnt_q <= bit_cnt_d;
         rx_q      <= rx_d;
         shift_q   <= shift_d;
         wdata_q   <= wdata_d;
         addr_q    <= addr_d;
         to_q      <= to_d;
         inc_q     <= inc_d;
         changed_q <= changed_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         unr_q     <= unr_d;
      end

   // Strobes are held while ena is low and released once it returns.
   assign bus.reg_wr      = wr_q & ena;
   assign bus.reg_rd      = rd_q & ena;
   assign bus.reg_addr    = addr_q;
   assign bus.reg_wdata   = wdata_q;
   assign bus.busy        = state_q != IDLE;
   assign bus.rd_underrun = unr_q;
   assign bus.spi_miso    = (state_q == RD_DATA) & shift_q[REG_W-1];
endmodule

// File: tb/tb_spi_reg_burst.sv
// tb_spi_reg_burst: mode 0 and mode 3 instances on a shared SPI bus with separate chip selects;
// register writes and MISO words are checked against queues filled when stimulus is issued.
module tb_spi_reg_burst;
   localparam int HP = 10;

   logic clk = 1'b0;
   logic rstb, ena, sclk, mosi, cs0, cs3;
   int   nchk = 0, nfail = 0, rd_cnt0 = 0, rd_cnt3 = 0, rd_dly = 2;
   logic [13:0] exp_wr0[$];
   logic [7:0]  exp_rd[$];
   logic [13:0] wr_e;
   logic [7:0]  rx_word;
   logic [5:0]  a0, a3;
   event        rx_ev;

   always #5 clk = ~clk;

   spi_reg_burst_if #(.ADDR_W(6), .REG_W(8)) if0 ();
   spi_reg_burst_if #(.ADDR_W(6), .REG_W(8)) if3 ();

   assign if0.spi_clk  = sclk;
   assign if0.spi_mosi = mosi;
   assign if0.spi_cs_n = cs0;
   assign if3.spi_clk  = sclk;
   assign if3.spi_mosi = mosi;
   assign if3.spi_cs_n = cs3;

   spi_reg_burst #(.ADDR_W(6), .REG_W(8), .CPOL(1'b0), .CPHA(1'b0), .RD_TIMEOUT(4)) u0 (
      .clk(clk), .rstb(rstb), .ena(ena), .bus(if0));
   spi_reg_burst #(.ADDR_W(6), .REG_W(8), .CPOL(1'b1), .CPHA(1'b1), .RD_TIMEOUT(4)) u3 (
      .clk(clk), .rstb(rstb), .ena(ena), .bus(if3));

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
      end
   endtask

   task automatic wt(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sbit(input int dev, input logic b, output logic r);
      logic cpol, cpha;
      cpol = dev == 3;
      cpha = dev == 3;
      if (!cpha) begin
         mosi = b;
         wt(HP);
         r = (dev == 3) ? if3.spi_miso : if0.spi_miso;
         sclk = ~cpol;
         wt(HP);
         sclk = cpol;
      end else begin
         sclk = ~cpol;
         mosi = b;
         wt(HP);
         r = (dev == 3) ? if3.spi_miso : if0.spi_miso;
         sclk = cpol;
         wt(HP);
      end
   endtask

   task automatic send(input int dev, input logic [7:0] d, input int n, output logic [7:0] r);
      logic b;
      r = '0;
      for (int i = 0; i < n; i++) begin
         sbit(dev, d[7-i], b);
         r = {r[6:0], b};
      end
   endtask

   task automatic cs_low(input int dev);
      wt(HP);
      sclk = dev == 3;
      wt(HP);
      if (dev == 3) cs3 = 1'b0;
      else cs0 = 1'b0;
      wt(HP);
   endtask

   task automatic cs_high(input int dev);
      wt(HP);
      if (dev == 3) cs3 = 1'b1;
      else cs0 = 1'b1;
      wt(HP);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_addr"}, 32'(if0.reg_addr), 0);
      chk({tag, "_wdata"}, 32'(if0.reg_wdata), 0);
      chk({tag, "_wr"}, 32'(if0.reg_wr), 0);
      chk({tag, "_rd"}, 32'(if0.reg_rd), 0);
      chk({tag, "_busy"}, 32'(if0.busy), 0);
      chk({tag, "_unr"}, 32'(if0.rd_underrun), 0);
      chk({tag, "_miso"}, 32'(if0.spi_miso), 0);
   endtask

   // Register-file responders: 0xA0+addr, rd_dly cycles after reg_rd.
   initial begin
      if0.reg_rdata_dv = 1'b0;
      if0.reg_rdata = '0;
      forever begin
         @(negedge clk);
         if (if0.reg_rd) begin
            a0 = if0.reg_addr;
            repeat (rd_dly) @(posedge clk);
            #1;
            if0.reg_rdata = 8'hA0 + {2'b00, a0};
            if0.reg_rdata_dv = 1'b1;
            @(posedge clk);
            #1;
            if0.reg_rdata_dv = 1'b0;
         end
      end
   end

   initial begin
      if3.reg_rdata_dv = 1'b0;
      if3.reg_rdata = '0;
      forever begin
         @(negedge clk);
         if (if3.reg_rd) begin
            a3 = if3.reg_addr;
            repeat (rd_dly) @(posedge clk);
            #1;
            if3.reg_rdata = 8'hA0 + {2'b00, a3};
            if3.reg_rdata_dv = 1'b1;
            @(posedge clk);
            #1;
            if3.reg_rdata_dv = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (if0.reg_rd) rd_cnt0++;
      if (if3.reg_rd) rd_cnt3++;
      if (if3.reg_wr) begin
         nchk++;
         nfail++;
         $display("FAIL wr3_unexpected actual=1 expected=0");
      end
      if (if0.reg_wr) begin
         if (exp_wr0.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL wr0_unexpected addr=%0h data=%0h expected=none", if0.reg_addr, if0.reg_wdata);
         end else begin
            wr_e = exp_wr0.pop_front();
            chk("wr0_addr", 32'(if0.reg_addr), 32'(wr_e[13:8]));
            chk("wr0_data", 32'(if0.reg_wdata), 32'(wr_e[7:0]));
         end
      end
   end

   initial forever begin
      @(rx_ev);
      if (exp_rd.size() == 0) begin
         nchk++;
         nfail++;
         $display("FAIL rd_unexpected actual=%0h expected=none", rx_word);
      end else chk("rd_word", 32'(rx_word), 32'(exp_rd.pop_front()));
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r;
      rstb = 1'b0; ena = 1'b1; cs0 = 1'b1; cs3 = 1'b1; sclk = 1'b0; mosi = 1'b0;
      wt(5);
      chk_reset("rst");
      chk("rst3_busy", 32'(if3.busy), 0);
      chk("rst3_addr", 32'(if3.reg_addr), 0);
      rstb = 1'b1;
      wt(5);
      // single write, mode 0
      exp_wr0.push_back({6'h05, 8'h3C});
      cs_low(0);
      send(0, 8'hC5, 8, r);
      send(0, 8'h3C, 8, r);
      chk("busy_in_frame", 32'(if0.busy), 1);
      cs_high(0);
      chk("busy_after_cs", 32'(if0.busy), 0);
      chk("addr_after_inc", 32'(if0.reg_addr), 6);
      // burst write wrapping 0x3F -> 0x00
      exp_wr0.push_back({6'h3E, 8'h11});
      exp_wr0.push_back({6'h3F, 8'h22});
      exp_wr0.push_back({6'h00, 8'h33});
      cs_low(0);
      send(0, 8'hFE, 8, r);
      send(0, 8'h11, 8, r);
      send(0, 8'h22, 8, r);
      send(0, 8'h33, 8, r);
      cs_high(0);
      chk("burst_addr_end", 32'(if0.reg_addr), 1);
      // mode 3 burst read with prefetch
      rd_cnt3 = 0;
      exp_rd.push_back(8'hA2);
      exp_rd.push_back(8'hA3);
      cs_low(3);
      send(3, 8'h42, 8, r);
      send(3, 8'h00, 8, r);
      rx_word = r;
      ->rx_ev;
      send(3, 8'h00, 8, r);
      rx_word = r;
      ->rx_ev;
      cs_high(3);
      chk("rd3_count", 32'(rd_cnt3), 3);
      chk("rd3_addr_end", 32'(if3.reg_addr), 4);
      chk("rd3_unr", 32'(if3.rd_underrun), 0);
      chk("rd3_busy", 32'(if3.busy), 0);
      // late read data -> zeros and sticky underrun
      rd_dly = 10;
      rd_cnt0 = 0;
      exp_rd.push_back(8'h00);
      cs_low(0);
      send(0, 8'h07, 8, r);
      send(0, 8'h00, 8, r);
      rx_word = r;
      ->rx_ev;
      chk("unr_set", 32'(if0.rd_underrun), 1);
      cs_high(0);
      wt(20);
      chk("unr_sticky", 32'(if0.rd_underrun), 1);
      chk("rd0_count", 32'(rd_cnt0), 2);
      chk("rd0_addr_noinc", 32'(if0.reg_addr), 7);
      rd_dly = 2;
      // next frame clears underrun; abort after 5 data bits
      cs_low(0);
      chk("unr_cleared", 32'(if0.rd_underrun), 0);
      send(0, 8'h8A, 8, r);
      send(0, 8'hFF, 5, r);
      cs_high(0);
      chk("abort_busy", 32'(if0.busy), 0);
      exp_wr0.push_back({6'h0A, 8'h5A});
      cs_low(0);
      send(0, 8'h8A, 8, r);
      send(0, 8'h5A, 8, r);
      cs_high(0);
      chk("after_abort_addr", 32'(if0.reg_addr), 32'h0A);
      // reset in the middle of a write frame
      cs_low(0);
      send(0, 8'hC5, 8, r);
      send(0, 8'hF0, 3, r);
      rstb = 1'b0;
      wt(2);
      chk_reset("midrst");
      rstb = 1'b1;
      wt(2);
      send(0, 8'h00, 5, r);
      chk("midrst_ignored_busy", 32'(if0.busy), 0);
      cs_high(0);
      // ena-low window mid-word
      exp_wr0.push_back({6'h01, 8'h96});
      cs_low(0);
      send(0, 8'h81, 8, r);
      send(0, 8'h96, 3, r);
      ena = 1'b0;
      wt(2);
      for (int i = 0; i < 2; i++) begin
         sclk = 1'b1;
         wt(HP);
         sclk = 1'b0;
         wt(HP);
      end
      chk("ena_low_busy", 32'(if0.busy), 1);
      chk("ena_low_wr", 32'(if0.reg_wr), 0);
      ena = 1'b1;
      wt(4);
      send(0, 8'hB0, 5, r);
      cs_high(0);
      chk("ena_addr", 32'(if0.reg_addr), 1);
      wt(10);
      chk("wr_queue_empty", 32'(exp_wr0.size()), 0);
      chk("rd_queue_empty", 32'(exp_rd.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
